// File: rtl/ibex_register_file_mp.sv
// ibex_register_file_mp
// Flop-based register file with NumRead combinational read ports, NumWrite
// write ports, an optional same-cycle write-to-read bypass and a per-register
// pending-write scoreboard. x0 is hardwired to zero in both the data array and
// the scoreboard.
module ibex_register_file_mp #(
  parameter bit          RV32E        = 1'b0,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned NumRead      = 2,
  parameter int unsigned NumWrite     = 1,
  parameter bit          WriteForward = 1'b0
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumRead*5-1:0]          raddr_i,
  output logic [NumRead*DataWidth-1:0]  rdata_o,
  output logic [NumRead-1:0]            rbusy_o,
  input  logic [NumWrite*5-1:0]         waddr_i,
  input  logic [NumWrite*DataWidth-1:0] wdata_i,
  input  logic [NumWrite-1:0]           we_i,
  input  logic                          sb_set_i,
  input  logic [4:0]                    sb_set_addr_i,
  input  logic [NumWrite-1:0]           sb_clr_i,
  output logic [(RV32E ? 16 : 32)-1:0]  busy_vec_o
);

  localparam int unsigned ADDR_WIDTH = RV32E ? 4 : 5;
  localparam int unsigned NUM_WORDS  = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] addr_t;

  // Out-of-range port counts are a configuration error, caught at elaboration.
  if (NumRead < 1 || NumRead > 4) begin : gen_bad_num_read
    $error("ibex_register_file_mp: NumRead must be in 1..4");
  end
  if (NumWrite < 1 || NumWrite > 2) begin : gen_bad_num_write
    $error("ibex_register_file_mp: NumWrite must be in 1..2");
  end

  addr_t                 raddr [NumRead];
  addr_t                 waddr [NumWrite];
  logic [DataWidth-1:0]  wdata [NumWrite];
  addr_t                 set_addr;

  logic [NUM_WORDS-1:0][DataWidth-1:0] rf_q, rf_d;
  logic [NUM_WORDS-1:0]                busy_q, busy_d;

  // With RV32E the top address bit is dropped, so it is deliberately left unread.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{raddr_i, waddr_i, sb_set_addr_i};

  // Unpack the flat port buses; only the low ADDR_WIDTH bits select a register.
  always_comb begin
    for (int k = 0; k < NumRead; k++) begin
      raddr[k] = raddr_i[5*k +: ADDR_WIDTH];
    end
    for (int j = 0; j < NumWrite; j++) begin
      waddr[j] = waddr_i[5*j +: ADDR_WIDTH];
      wdata[j] = wdata_i[DataWidth*j +: DataWidth];
    end
    set_addr = sb_set_addr_i[ADDR_WIDTH-1:0];
  end

  // Next register state: later write ports overwrite earlier ones, x0 stays zero.
  always_comb begin
    rf_d = rf_q;
    for (int j = 0; j < NumWrite; j++) begin
      if (we_i[j]) begin
        rf_d[waddr[j]] = wdata[j];
      end
    end
    rf_d[0] = '0;
  end

  // Next scoreboard state: retiring writes clear, a new producer set overrides a clear.
  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NumWrite; j++) begin
      if (we_i[j] && sb_clr_i[j]) begin
        busy_d[waddr[j]] = 1'b0;
      end
    end
    if (sb_set_i) begin
      busy_d[set_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State registers for the data array and the scoreboard.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_q   <= '0;
      busy_q <= '0;
    end else begin
      rf_q   <= rf_d;
      busy_q <= busy_d;
    end
  end

  // Read ports with optional bypass; the bypass is gated by reset so outputs stay zero in reset.
  always_comb begin
    rdata_o = '0;
    rbusy_o = '0;
    for (int k = 0; k < NumRead; k++) begin
      rdata_o[k*DataWidth +: DataWidth] = rf_q[raddr[k]];
      rbusy_o[k]                        = busy_q[raddr[k]];
      if (WriteForward && rst_ni && (raddr[k] != '0)) begin
        for (int j = 0; j < NumWrite; j++) begin
          if (we_i[j] && (waddr[j] == raddr[k])) begin
            rdata_o[k*DataWidth +: DataWidth] = wdata[j];
            if (sb_clr_i[j]) begin
              rbusy_o[k] = 1'b0;
            end
          end
        end
        if (sb_set_i && (set_addr == raddr[k])) begin
          rbusy_o[k] = busy_q[raddr[k]];
        end
      end
    end
  end

  assign busy_vec_o = busy_q;

endmodule

// File: tb/tb_ibex_register_file_mp.sv
// tb_ibex_register_file_mp
// Directed checks of three register file configurations: plain (no bypass,
// one write port), bypass with two write ports, and RV32E.
module tb_ibex_register_file_mp;

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  // Configuration A: RV32E=0, NumRead=2, NumWrite=1, WriteForward=0
  logic [9:0]  a_raddr;
  logic [63:0] a_rdata;
  logic [1:0]  a_rbusy;
  logic [4:0]  a_waddr;
  logic [31:0] a_wdata;
  logic        a_we;
  logic        a_sb_set;
  logic [4:0]  a_sb_addr;
  logic        a_sb_clr;
  logic [31:0] a_busy_vec;

  // Configuration B: RV32E=0, NumRead=2, NumWrite=2, WriteForward=1
  logic [9:0]  b_raddr;
  logic [63:0] b_rdata;
  logic [1:0]  b_rbusy;
  logic [9:0]  b_waddr;
  logic [63:0] b_wdata;
  logic [1:0]  b_we;
  logic        b_sb_set;
  logic [4:0]  b_sb_addr;
  logic [1:0]  b_sb_clr;
  logic [31:0] b_busy_vec;

  // Configuration C: RV32E=1, NumRead=1, NumWrite=1, WriteForward=0
  logic [4:0]  c_raddr;
  logic [31:0] c_rdata;
  logic        c_rbusy;
  logic [4:0]  c_waddr;
  logic [31:0] c_wdata;
  logic        c_we;
  logic        c_sb_set;
  logic [4:0]  c_sb_addr;
  logic        c_sb_clr;
  logic [15:0] c_busy_vec;

  ibex_register_file_mp #(
    .RV32E(1'b0), .DataWidth(32), .NumRead(2), .NumWrite(1), .WriteForward(1'b0)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .raddr_i(a_raddr), .rdata_o(a_rdata), .rbusy_o(a_rbusy),
    .waddr_i(a_waddr), .wdata_i(a_wdata), .we_i(a_we),
    .sb_set_i(a_sb_set), .sb_set_addr_i(a_sb_addr), .sb_clr_i(a_sb_clr),
    .busy_vec_o(a_busy_vec)
  );

  ibex_register_file_mp #(
    .RV32E(1'b0), .DataWidth(32), .NumRead(2), .NumWrite(2), .WriteForward(1'b1)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .raddr_i(b_raddr), .rdata_o(b_rdata), .rbusy_o(b_rbusy),
    .waddr_i(b_waddr), .wdata_i(b_wdata), .we_i(b_we),
    .sb_set_i(b_sb_set), .sb_set_addr_i(b_sb_addr), .sb_clr_i(b_sb_clr),
    .busy_vec_o(b_busy_vec)
  );

  ibex_register_file_mp #(
    .RV32E(1'b1), .DataWidth(32), .NumRead(1), .NumWrite(1), .WriteForward(1'b0)
  ) dut_c (
    .clk_i(clk), .rst_ni(rst_n),
    .raddr_i(c_raddr), .rdata_o(c_rdata), .rbusy_o(c_rbusy),
    .waddr_i(c_waddr), .wdata_i(c_wdata), .we_i(c_we),
    .sb_set_i(c_sb_set), .sb_set_addr_i(c_sb_addr), .sb_clr_i(c_sb_clr),
    .busy_vec_o(c_busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives every input of configuration A in one call.
  task automatic applyStimulus(input logic [4:0] ra0, input logic [4:0] ra1,
                               input logic we, input logic [4:0] wa,
                               input logic [31:0] wd, input logic sbs,
                               input logic [4:0] sba, input logic sbc);
    a_raddr   = {ra1, ra0};
    a_we      = we;
    a_waddr   = wa;
    a_wdata   = wd;
    a_sb_set  = sbs;
    a_sb_addr = sba;
    a_sb_clr  = sbc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleB();
    b_we = 2'b00; b_waddr = '0; b_wdata = '0;
    b_sb_set = 1'b0; b_sb_addr = '0; b_sb_clr = 2'b00;
  endtask

  task automatic idleC();
    c_we = 1'b0; c_waddr = '0; c_wdata = '0;
    c_sb_set = 1'b0; c_sb_addr = '0; c_sb_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    idleB();
    b_raddr = '0;
    idleC();
    c_raddr = '0;

    // Reset held low
    #2;
    checkOutput("rst_low_rdata_a", a_rdata, 64'h0);
    checkOutput("rst_low_busy_a", {32'h0, a_busy_vec}, 64'h0);
    checkOutput("rst_low_rbusy_a", {62'h0, a_rbusy}, 64'h0);
    #10;
    rst_n = 1'b1;
    tick();

    // Every address reads zero after reset
    for (int i = 0; i < 32; i++) begin
      applyStimulus(i[4:0], 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
      #1;
      checkOutput($sformatf("rst_read_x%0d", i), {32'h0, a_rdata[31:0]}, 64'h0);
    end
    checkOutput("rst_busy_b", {32'h0, b_busy_vec}, 64'h0);
    checkOutput("rst_busy_c", {48'h0, c_busy_vec}, 64'h0);

    // Basic write/read without bypass: one cycle latency
    applyStimulus(5'd5, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0);
    #1;
    checkOutput("a_raw_same_cycle", {32'h0, a_rdata[31:0]}, 64'h0);
    tick();
    applyStimulus(5'd5, 5'd5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    #1;
    checkOutput("a_raw_next_p0", {32'h0, a_rdata[31:0]}, 64'hDEADBEEF);
    checkOutput("a_raw_next_p1", {32'h0, a_rdata[63:32]}, 64'hDEADBEEF);

    // Write to x0 is discarded
    applyStimulus(5'd0, 5'd5, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 1'b0);
    tick();
    applyStimulus(5'd0, 5'd5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    #1;
    checkOutput("a_x0_zero", {32'h0, a_rdata[31:0]}, 64'h0);
    checkOutput("a_x5_kept", {32'h0, a_rdata[63:32]}, 64'hDEADBEEF);

    // Scoreboard set on x10
    applyStimulus(5'd0, 5'd10, 1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 1'b0);
    #1;
    checkOutput("a_sb_before_edge", {62'h0, a_rbusy}, 64'h0);
    tick();
    applyStimulus(5'd0, 5'd10, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    #1;
    checkOutput("a_sb_set_vec", {32'h0, a_busy_vec}, 64'h400);
    checkOutput("a_sb_set_rbusy", {62'h0, a_rbusy}, 64'h2);

    // Clearing write: no bypass, so busy still visible this cycle
    applyStimulus(5'd0, 5'd10, 1'b1, 5'd10, 32'hCAFE, 1'b0, 5'd0, 1'b1);
    #1;
    checkOutput("a_sb_clr_same_cycle", {62'h0, a_rbusy}, 64'h2);
    tick();
    applyStimulus(5'd0, 5'd10, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    #1;
    checkOutput("a_sb_clr_vec", {32'h0, a_busy_vec}, 64'h0);
    checkOutput("a_sb_clr_data", {32'h0, a_rdata[63:32]}, 64'hCAFE);

    // Set and clear together: set wins
    applyStimulus(5'd0, 5'd10, 1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 1'b0);
    tick();
    applyStimulus(5'd0, 5'd10, 1'b1, 5'd10, 32'hF00D, 1'b1, 5'd10, 1'b1);
    tick();
    applyStimulus(5'd0, 5'd10, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    #1;
    checkOutput("a_sb_set_wins", {32'h0, a_busy_vec}, 64'h400);

    // Clear without write enable, set of x0, and write without clear: no effect
    applyStimulus(5'd0, 5'd10, 1'b0, 5'd10, 32'h0, 1'b1, 5'd0, 1'b1);
    tick();
    applyStimulus(5'd0, 5'd10, 1'b1, 5'd10, 32'hBEEF, 1'b0, 5'd0, 1'b0);
    tick();
    applyStimulus(5'd0, 5'd10, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    #1;
    checkOutput("a_sb_no_effect", {32'h0, a_busy_vec}, 64'h400);
    checkOutput("a_write_no_clr_data", {32'h0, a_rdata[63:32]}, 64'hBEEF);

    // Bypass with two write ports hitting x7: port 1 wins
    b_we = 2'b11; b_waddr = {5'd7, 5'd7};
    b_wdata = {32'h5555FFFF, 32'hAAAA0000};
    b_raddr = {5'd7, 5'd0};
    #1;
    checkOutput("b_fwd_priority", {32'h0, b_rdata[63:32]}, 64'h5555FFFF);
    checkOutput("b_fwd_x0_port0", {32'h0, b_rdata[31:0]}, 64'h0);
    tick();
    idleB();
    #1;
    checkOutput("b_write_priority", {32'h0, b_rdata[63:32]}, 64'h5555FFFF);

    // Bypass never forwards x0
    b_we = 2'b01; b_waddr = {5'd0, 5'd0}; b_wdata = {32'h0, 32'h1234};
    #1;
    checkOutput("b_fwd_x0", {32'h0, b_rdata[31:0]}, 64'h0);
    tick();
    idleB();

    // Scoreboard with bypass: clearing write hides busy, a same-cycle set keeps it
    b_sb_set = 1'b1; b_sb_addr = 5'd12;
    tick();
    idleB();
    b_raddr = {5'd12, 5'd12};
    #1;
    checkOutput("b_sb_busy", {62'h0, b_rbusy}, 64'h3);
    b_we = 2'b10; b_waddr = {5'd12, 5'd0}; b_wdata = {32'h00C0FFEE, 32'h0};
    b_sb_clr = 2'b10;
    #1;
    checkOutput("b_sb_clr_fwd", {62'h0, b_rbusy}, 64'h0);
    checkOutput("b_fwd_data_p0", {32'h0, b_rdata[31:0]}, 64'h00C0FFEE);
    b_sb_set = 1'b1; b_sb_addr = 5'd12;
    #1;
    checkOutput("b_sb_clr_with_set", {62'h0, b_rbusy}, 64'h3);
    tick();
    idleB();
    #1;
    checkOutput("b_sb_set_wins", {32'h0, b_busy_vec}, 64'h1000);

    // RV32E: address bit 4 ignored
    c_we = 1'b1; c_waddr = 5'b10011; c_wdata = 32'h77;
    tick();
    idleC();
    c_raddr = 5'd3;
    #1;
    checkOutput("c_alias_x3", {32'h0, c_rdata}, 64'h77);
    c_raddr = 5'b10011;
    #1;
    checkOutput("c_alias_x19", {32'h0, c_rdata}, 64'h77);
    c_sb_set = 1'b1; c_sb_addr = 5'b11010;
    tick();
    idleC();
    #1;
    checkOutput("c_sb_alias", {48'h0, c_busy_vec}, 64'h0400);
    checkOutput("c_rbusy_x19", {63'h0, c_rbusy}, 64'h0);

    // Fill x1..x31 and mark x20 busy, then reset between clock edges
    for (int i = 1; i < 32; i++) begin
      applyStimulus(5'd0, 5'd0, 1'b1, i[4:0], 32'h100 + i, 1'b0, 5'd0, 1'b0);
      tick();
    end
    applyStimulus(5'd31, 5'd7, 1'b0, 5'd0, 32'h0, 1'b1, 5'd20, 1'b0);
    tick();
    applyStimulus(5'd31, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    b_raddr = {5'd7, 5'd12};
    c_raddr = 5'd3;
    #1;
    checkOutput("a_fill_x31", {32'h0, a_rdata[31:0]}, 64'h11F);
    checkOutput("a_fill_x7", {32'h0, a_rdata[63:32]}, 64'h107);
    checkOutput("a_fill_busy", {32'h0, a_busy_vec}, 64'h00100400);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_rdata_a", a_rdata, 64'h0);
    checkOutput("async_rst_busy_a", {32'h0, a_busy_vec}, 64'h0);
    checkOutput("async_rst_rdata_b", b_rdata, 64'h0);
    checkOutput("async_rst_busy_b", {32'h0, b_busy_vec}, 64'h0);
    checkOutput("async_rst_rdata_c", {32'h0, c_rdata}, 64'h0);
    checkOutput("async_rst_busy_c", {48'h0, c_busy_vec}, 64'h0);
    #10;
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
